// File: rtl/codegen_tapline.sv
// codegen_tapline: GPS C/A code generator with early/prompt/late tap line, code-phase counter
// and chip-slew handshake. Define CODEGEN_VEVL_EN to add very-early/very-late taps (pnve/pnvl).
module codegen_tapline #(
    parameter int unsigned EL_SPACING       = 1,
    parameter int unsigned SAMPLES_PER_CHIP = 2
) (
    input  logic        clk,
    input  logic        res,
    input  logic        chip_en,
    input  logic        sample_en,
    input  logic        car_change,
    input  logic [4:0]  code_sel,
    input  logic        slew_req,
    input  logic [10:0] slew_cnt,
    output logic        slew_ack,
    output logic        pne,
    output logic        pnp,
    output logic        pnl,
`ifdef CODEGEN_VEVL_EN
    output logic        pnve,
    output logic        pnvl,
`endif
    output logic        epochrx,
    output logic [9:0]  code_phase
);

`ifdef CODEGEN_VEVL_EN
    localparam int unsigned DEPTH = 4 * EL_SPACING + 1;
    localparam int unsigned TAP_E = EL_SPACING;
`else
    localparam int unsigned DEPTH = 2 * EL_SPACING + 1;
    localparam int unsigned TAP_E = 0;
`endif
    localparam int unsigned TAP_P = TAP_E + EL_SPACING;
    localparam int unsigned TAP_L = TAP_P + EL_SPACING;
    localparam int unsigned CNT_W = 11;
    localparam int unsigned PH_W  = 10;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(1022);

    // G2 phase-selector stage pairs (1-based stage numbers as nibbles), PRN 1..32
    localparam logic [7:0] G2_SEL [32] = '{
        8'h26, 8'h37, 8'h48, 8'h59, 8'h19, 8'h2A, 8'h18, 8'h29,
        8'h3A, 8'h23, 8'h34, 8'h56, 8'h67, 8'h78, 8'h89, 8'h9A,
        8'h14, 8'h25, 8'h36, 8'h47, 8'h58, 8'h69, 8'h13, 8'h46,
        8'h57, 8'h68, 8'h79, 8'h8A, 8'h16, 8'h27, 8'h38, 8'h49
    };

    if (EL_SPACING == 0 || EL_SPACING > 16 || SAMPLES_PER_CHIP == 0) begin : g_param_chk
        $error("codegen_tapline: EL_SPACING must be 1..16 and SAMPLES_PER_CHIP nonzero");
    end

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SLEW = 2'd1, ST_ACK = 2'd2} state_t;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [9:0]        r_g1, r_g2, w_g1_nxt, w_g2_nxt;
    logic              r_chip, w_chip_nxt;
    logic [PH_W-1:0]   r_phase;
    logic              r_epoch, r_ack;
    logic [DEPTH-1:0]  r_tap;
    logic [4:0]        r_sel, w_sel;
    logic              r_sel_vld;
    logic [7:0]        w_pair;
    logic              w_step, w_cnt_load, w_cnt_dec, w_ack_d;

    // Until the first clock after reset the PRN comes straight from code_sel
    assign w_sel  = r_sel_vld ? r_sel : code_sel;
    assign w_pair = G2_SEL[w_sel];

    assign w_g1_nxt   = {r_g1[8:0], r_g1[2] ^ r_g1[9]};
    assign w_g2_nxt   = {r_g2[8:0], r_g2[1] ^ r_g2[2] ^ r_g2[5] ^ r_g2[7] ^ r_g2[8] ^ r_g2[9]};
    assign w_chip_nxt = w_g1_nxt[9] ^ w_g2_nxt[w_pair[7:4] - 4'd1] ^ w_g2_nxt[w_pair[3:0] - 4'd1];

    always_ff @(posedge clk or negedge res) begin
        if (!res) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (slew_req) w_state_nxt = (slew_cnt == '0) ? ST_ACK : ST_SLEW;
            ST_SLEW: if (car_change || (chip_en && r_cnt == CNT_W'(1))) w_state_nxt = ST_ACK;
            ST_ACK:  if (!slew_req) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Chip strobes are swallowed while slewing; ack stays up only while ACK persists
    always_comb begin
        w_step     = 1'b0;
        w_cnt_load = 1'b0;
        w_cnt_dec  = 1'b0;
        w_ack_d    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_step     = chip_en && !car_change;
                w_cnt_load = slew_req;
            end
            ST_SLEW: w_cnt_dec = chip_en && !car_change;
            ST_ACK: begin
                w_step  = chip_en && !car_change;
                w_ack_d = slew_req;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_g1      <= '1;
            r_g2      <= '1;
            r_chip    <= 1'b1;
            r_phase   <= '0;
            r_epoch   <= 1'b0;
            r_ack     <= 1'b0;
            r_tap     <= '0;
            r_cnt     <= '0;
            r_sel     <= '0;
            r_sel_vld <= 1'b0;
        end else begin
            r_ack     <= w_ack_d;
            r_epoch   <= 1'b0;
            r_sel_vld <= 1'b1;
            if (sample_en) r_tap <= {r_tap[DEPTH-2:0], r_chip};
            if (car_change || !r_sel_vld) r_sel <= code_sel;
            if (w_cnt_load)     r_cnt <= slew_cnt;
            else if (w_cnt_dec) r_cnt <= r_cnt - CNT_W'(1);
            if (car_change) begin
                r_g1    <= '1;
                r_g2    <= '1;
                r_chip  <= 1'b1;
                r_phase <= '0;
                r_epoch <= 1'b1;
            end else if (w_step) begin
                r_g1    <= w_g1_nxt;
                r_g2    <= w_g2_nxt;
                r_chip  <= w_chip_nxt;
                r_epoch <= (r_phase == PH_LAST);
                r_phase <= (r_phase == PH_LAST) ? '0 : r_phase + PH_W'(1);
            end
        end
    end

    assign pne        = r_tap[TAP_E];
    assign pnp        = r_tap[TAP_P];
    assign pnl        = r_tap[TAP_L];
`ifdef CODEGEN_VEVL_EN
    assign pnve       = r_tap[0];
    assign pnvl       = r_tap[DEPTH-1];
`endif
    assign epochrx    = r_epoch;
    assign slew_ack   = r_ack;
    assign code_phase = r_phase;

endmodule

// File: tb/tb_codegen_tapline.sv
// Scoreboard bench for codegen_tapline: driver pushes expected outputs per cycle, monitor compares.
module tb_codegen_tapline;

`ifdef CODEGEN_VEVL_EN
    localparam int unsigned EL    = 2;
    localparam int unsigned DEPTH = 4 * EL + 1;
    localparam int unsigned TE    = EL;
`else
    localparam int unsigned EL    = 1;
    localparam int unsigned DEPTH = 2 * EL + 1;
    localparam int unsigned TE    = 0;
`endif

    logic        clk, res, chip_en, sample_en, car_change, slew_req;
    logic [4:0]  code_sel;
    logic [10:0] slew_cnt;
    logic        slew_ack, pne, pnp, pnl, epochrx;
    logic [9:0]  code_phase;
`ifdef CODEGEN_VEVL_EN
    logic        pnve, pnvl;
`endif

    codegen_tapline #(.EL_SPACING(EL), .SAMPLES_PER_CHIP(2)) dut (
        .clk(clk), .res(res), .chip_en(chip_en), .sample_en(sample_en),
        .car_change(car_change), .code_sel(code_sel), .slew_req(slew_req),
        .slew_cnt(slew_cnt), .slew_ack(slew_ack), .pne(pne), .pnp(pnp), .pnl(pnl),
`ifdef CODEGEN_VEVL_EN
        .pnve(pnve), .pnvl(pnvl),
`endif
        .epochrx(epochrx), .code_phase(code_phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        bit         pne, pnp, pnl, pnve, pnvl, epoch, ack;
        int         phase;
        bit         cap, chk;
        logic [9:0] cap_exp;
    } exp_t;

    exp_t       sb[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_wrap_ep = 0;
    logic [9:0] cap_reg = '0;
    bit         nx_cap = 0, nx_chk = 0;
    logic [9:0] nx_cap_exp = '0;

    // Reference model state (1-based LFSR stages)
    bit mg1 [1:10];
    bit mg2 [1:10];
    bit mchip, mepoch, mack;
    int mphase, mstate, mcnt, msel;
    bit mtap [DEPTH];
    int g2a [32] = '{2,3,4,5,1,2,1,2,3,2,3,5,6,7,8,9,1,2,3,4,5,6,1,4,5,6,7,8,1,2,3,4};
    int g2b [32] = '{6,7,8,9,9,10,8,9,10,3,4,6,7,8,9,10,4,5,6,7,8,9,3,6,7,8,9,10,6,7,8,9};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic model_reset();
        for (int k = 1; k <= 10; k++) begin mg1[k] = 1; mg2[k] = 1; end
        for (int k = 0; k < DEPTH; k++) mtap[k] = 0;
        mchip = 1; mphase = 0; mepoch = 0; mack = 0; mstate = 0; mcnt = 0;
        msel = int'(code_sel);
    endtask

    task automatic model_step(input bit ce, input bit se, input bit cc, input bit req, input int cnt);
        int nstate;
        bit step, f1, f2;
        step   = ce && !cc && (mstate != 1);
        nstate = mstate;
        case (mstate)
            0: if (req) begin mcnt = cnt; nstate = (cnt == 0) ? 2 : 1; end
            1: if (cc) nstate = 2;
               else if (ce) begin mcnt = mcnt - 1; if (mcnt == 0) nstate = 2; end
            default: if (!req) nstate = 0;
        endcase
        if (se) begin
            for (int k = DEPTH - 1; k >= 1; k--) mtap[k] = mtap[k-1];
            mtap[0] = mchip;
        end
        mepoch = 0;
        if (cc) begin
            for (int k = 1; k <= 10; k++) begin mg1[k] = 1; mg2[k] = 1; end
            msel = int'(code_sel); mchip = 1; mphase = 0; mepoch = 1;
        end else if (step) begin
            f1 = mg1[3] ^ mg1[10];
            f2 = mg2[2] ^ mg2[3] ^ mg2[6] ^ mg2[8] ^ mg2[9] ^ mg2[10];
            for (int k = 10; k >= 2; k--) begin mg1[k] = mg1[k-1]; mg2[k] = mg2[k-1]; end
            mg1[1] = f1; mg2[1] = f2;
            mchip  = mg1[10] ^ mg2[g2a[msel]] ^ mg2[g2b[msel]];
            mepoch = (mphase == 1022);
            mphase = (mphase + 1) % 1023;
        end
        mack   = (mstate == 2) && (nstate == 2);
        mstate = nstate;
    endtask

    task automatic push(input string tag);
        exp_t e;
        e.tag = tag; e.pne = mtap[TE]; e.pnp = mtap[TE+EL]; e.pnl = mtap[TE+2*EL];
        e.pnve = mtap[0]; e.pnvl = mtap[DEPTH-1];
        e.epoch = mepoch; e.ack = mack; e.phase = mphase;
        e.cap = nx_cap; e.chk = nx_chk; e.cap_exp = nx_cap_exp;
        nx_cap = 0; nx_chk = 0;
        sb.push_back(e);
    endtask

    // Called at a negedge; applies inputs for one rising edge and returns at the next negedge
    task automatic cyc(input string tag, input bit ce, input bit se, input bit cc, input bit req, input int cnt);
        chip_en = ce; sample_en = se; car_change = cc; slew_req = req; slew_cnt = 11'(cnt);
        @(posedge clk);
        model_step(ce, se, cc, req, cnt);
        push(tag);
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check({e.tag, "/pne"},        32'(pne),        32'(e.pne));
                check({e.tag, "/pnp"},        32'(pnp),        32'(e.pnp));
                check({e.tag, "/pnl"},        32'(pnl),        32'(e.pnl));
`ifdef CODEGEN_VEVL_EN
                check({e.tag, "/pnve"},       32'(pnve),       32'(e.pnve));
                check({e.tag, "/pnvl"},       32'(pnvl),       32'(e.pnvl));
`endif
                check({e.tag, "/epochrx"},    32'(epochrx),    32'(e.epoch));
                check({e.tag, "/slew_ack"},   32'(slew_ack),   32'(e.ack));
                check({e.tag, "/code_phase"}, 32'(code_phase), 32'(e.phase));
                if (e.tag == "wrap" && epochrx === 1'b1) n_wrap_ep++;
                if (e.cap) cap_reg = {cap_reg[8:0], pne};
                if (e.chk) check({e.tag, "/first10"}, 32'(cap_reg), 32'(e.cap_exp));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", sb.size());
        $fatal(1, "timeout");
    end

    initial begin : driver
        res = 1'b1; chip_en = 0; sample_en = 0; car_change = 0; slew_req = 0;
        slew_cnt = '0; code_sel = 5'd0;
        #2 res = 1'b0;
        model_reset();
        push("reset");
        @(negedge clk);
        res = 1'b1;

        // PRN 1 first ten chips, captured on pne: sample then step
        for (int j = 0; j < 10; j++) begin
            nx_cap = 1; nx_chk = (j == 9); nx_cap_exp = 10'o1440;
            cyc("prn1", 0, 1, 0, 0, 0);
            cyc("prn1", 1, 0, 0, 0, 0);
        end

        // Continuous sampling, chip every 2nd cycle, across two code-period wraps
        for (int i = 0; i < 4200; i++) cyc("wrap", i[0], 1, 0, 0, 0);

        // Slew of 5 chips, then release
        cyc("slew5", 0, 1, 0, 1, 5);
        for (int i = 0; i < 14; i++) cyc("slew5", i[0], 1, 0, 1, 5);
        for (int i = 0; i < 8; i++)  cyc("slew5_rel", i[0], 1, 0, 0, 0);

        // Zero-length slew
        for (int i = 0; i < 4; i++) cyc("slew0", i[0], 1, 0, 1, 0);
        for (int i = 0; i < 3; i++) cyc("slew0_rel", 0, 1, 0, 0, 0);

        // car_change aborts a slew of 3
        cyc("abort", 0, 1, 0, 1, 3);
        cyc("abort", 1, 1, 0, 1, 3);
        cyc("abort", 0, 1, 1, 1, 3);
        cyc("abort", 1, 1, 0, 1, 3);
        cyc("abort", 0, 1, 0, 1, 3);
        for (int i = 0; i < 4; i++) cyc("abort_rel", i[0], 1, 0, 0, 0);

        // Load PRN 5 and capture its first ten chips
        code_sel = 5'd4;
        cyc("sel5", 0, 1, 1, 0, 0);
        for (int j = 0; j < 10; j++) begin
            nx_cap = 1; nx_chk = (j == 9); nx_cap_exp = 10'o1133;
            cyc("prn5", 0, 1, 0, 0, 0);
            cyc("prn5", 1, 0, 0, 0, 0);
        end

        // code_sel change alone must not switch PRN
        code_sel = 5'd7;
        for (int i = 0; i < 8; i++) cyc("sel_hold", i[0], 1, 0, 0, 0);

        // chip_en, sample_en and car_change together, then PRN 8 first ten chips
        cyc("triple", 1, 1, 1, 0, 0);
        for (int j = 0; j < 10; j++) begin
            nx_cap = 1; nx_chk = (j == 9); nx_cap_exp = 10'o1454;
            cyc("prn8", 0, 1, 0, 0, 0);
            cyc("prn8", 1, 0, 0, 0, 0);
        end

        // Asynchronous reset in the middle of a slew
        for (int i = 0; i < 6; i++) cyc("fill", i[0], 1, 0, 0, 0);
        cyc("slew_rst", 0, 1, 0, 1, 50);
        cyc("slew_rst", 1, 1, 0, 1, 50);
        cyc("slew_rst", 1, 1, 0, 1, 50);
        chip_en = 1; sample_en = 1; car_change = 0; slew_req = 1; slew_cnt = 11'd50;
        @(posedge clk);
        model_step(1, 1, 0, 1, 50);
        #2 res = 1'b0;
        model_reset();
        push("async_rst");
        @(negedge clk);
        chip_en = 0; sample_en = 0; slew_req = 0; slew_cnt = '0;
        push("rst_hold");
        @(negedge clk);
        res = 1'b1;
        for (int i = 0; i < 8; i++) cyc("post_rst", i[0], 1, 0, 0, 0);

        repeat (2) @(negedge clk);
        check("sb_drain", 32'(sb.size()), 32'd0);
        check("wrap_epochs", 32'(n_wrap_ep), 32'd2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
